// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master request port between two requesters,
// with one outstanding transfer, a completion timeout and a done-release phase.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req0,
  input  logic        req1,
  input  logic        req_we0,
  input  logic        req_we1,
  input  logic [8:0]  req_addr0,
  input  logic [8:0]  req_addr1,
  input  logic [15:0] req_wdata0,
  input  logic [15:0] req_wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_done,
  output logic        rd_en,
  output logic [8:0]  rd_addr,
  input  logic [15:0] rd_data,
  input  logic        rd_done,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            busy_q, busy_d;

  logic            win_c;
  logic            we_sel_c;
  logic            done_sel_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_en_d      = wr_en_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    win_c        = 1'b0;
    we_sel_c     = 1'b0;
    done_sel_c   = wr_en_q ? wr_done : rd_done;
    cnt_inc_c    = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first
          win_c        = (req0 && req1) ? ~last_grant_q : req1;
          we_sel_c     = win_c ? req_we1 : req_we0;
          grant_d      = win_c;
          last_grant_d = win_c;
          addr_d       = win_c ? req_addr1 : req_addr0;
          data_d       = win_c ? req_wdata1 : req_wdata0;
          wr_en_d      = we_sel_c;
          rd_en_d      = ~we_sel_c;
          cnt_d        = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc_c;
        if (done_sel_c || (cnt_inc_c == CNT_W'(TIMEOUT))) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          state_d = S_RELEASE;
          if (grant_q) begin
            ack1_d = 1'b1;
            err1_d = ~done_sel_c;
          end else begin
            ack0_d = 1'b1;
            err0_d = ~done_sel_c;
          end
          if (done_sel_c && rd_en_q) begin
            if (grant_q) rdata1_d = rd_data;
            else         rdata0_d = rd_data;
          end
        end
      end
      S_RELEASE: begin
        // Wait out a lingering done level so it cannot complete the next transfer
        if (!wr_done && !rd_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: a scoreboard queue of expected acks
// is filled by each scenario task and drained by a negedge ack monitor.
module tb_apb_req_arbiter;

  logic        clk;
  logic        nreset;
  logic        req0, req1, req_we0, req_we1;
  logic [8:0]  req_addr0, req_addr1;
  logic [15:0] req_wdata0, req_wdata1;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic        wr_en, rd_en, wr_done, rd_done, busy, grant;
  logic [8:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;

  typedef struct {
    bit          id;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_req_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .nreset(nreset),
    .req0(req0), .req1(req1), .req_we0(req_we0), .req_we1(req_we1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input bit id, input bit err, input logic [15:0] rd);
    exp_t e;
    e.id = id; e.err = err; e.rdata = rd;
    return e;
  endfunction

  // Drains the scoreboard on every ack pulse
  task automatic ack_monitor();
    exp_t        e;
    bit          oid, oerr;
    logic [15:0] ord;
    forever begin
      @(negedge clk);
      if (nreset && (ack0 || ack1)) begin
        n_checks++;
        if (ack0 && ack1) begin
          n_fail++;
          $display("FAIL ack_onehot: ack0=%0b ack1=%0b, required exactly one", ack0, ack1);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b, required no ack", ack0, ack1);
        end else begin
          e    = exp_q.pop_front();
          oid  = ack1;
          oerr = ack1 ? err1 : err0;
          ord  = ack1 ? rdata1 : rdata0;
          if (oid !== e.id || oerr !== e.err || ord !== e.rdata || grant !== e.id) begin
            n_fail++;
            $display("FAIL ack_payload: id=%0b err=%0b rdata=%h grant=%0b, required id=%0b err=%0b rdata=%h",
                     oid, oerr, ord, grant, e.id, e.err, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic wait_en(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (is_wr ? wr_en : rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_en: is_wr=%0b enable stayed low for 20 cycles, required high", is_wr);
    end
  endtask

  // Raises done lat cycles after the call point and holds it for hold cycles
  task automatic drive_done(input bit is_wr, input int lat, input int hold,
                            input logic [15:0] data, input bit drop);
    repeat (lat) @(posedge clk);
    #1;
    rd_data = data;
    if (is_wr) wr_done = 1'b1;
    else       rd_done = 1'b1;
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      if (j == 0 && drop) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      n_checks++;
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL release_phase: wr_en=%0b rd_en=%0b busy=%0b, required 0 0 1", wr_en, rd_en, busy);
      end
    end
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    req0 = 0; req1 = 0; req_we0 = 0; req_we1 = 0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    wr_done = 0; rd_done = 0; rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({wr_en, rd_en, ack0, ack1, err0, err1, busy, grant} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en/ack/err/busy/grant=%b, required 00000000",
               {wr_en, rd_en, ack0, ack1, err0, err1, busy, grant});
    end
    n_checks++;
    if (wr_addr !== 9'h0 || wr_data !== 16'h0 || rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h rdata0=%h rdata1=%h, required all 0",
               wr_addr, wr_data, rdata0, rdata1);
    end
    @(negedge clk) nreset = 1'b1;
  endtask

  task automatic test_single_read();
    bit ok;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h00A1));
    req0 = 1; req_we0 = 0; req_addr0 = 9'h012;
    wait_en(1'b0, ok);
    n_checks++;
    if (rd_addr !== 9'h012 || wr_en !== 1'b0 || grant !== 1'b0) begin
      n_fail++;
      $display("FAIL read_issue: rd_addr=%h wr_en=%0b grant=%0b, required 012 0 0", rd_addr, wr_en, grant);
    end
    drive_done(1'b0, 2, 5, 16'h00A1, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_busy_hold: busy=%0b, required 1", busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0000));
    req1 = 1; req_we1 = 1; req_addr1 = 9'h085; req_wdata1 = 16'h1234;
    wait_en(1'b1, ok);
    n_checks++;
    if (wr_addr !== 9'h085 || wr_data !== 16'h1234 || rd_en !== 1'b0 || grant !== 1'b1) begin
      n_fail++;
      $display("FAIL write_issue: wr_addr=%h wr_data=%h rd_en=%0b grant=%0b, required 085 1234 0 1",
               wr_addr, wr_data, rd_en, grant);
    end
    drive_done(1'b1, 1, 2, 16'hDEAD, 1'b1);
    req_we1 = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    bit ok;
    exp_q.push_back(mk(1'b0, 1'b1, 16'h00A1));
    req0 = 1; req_we0 = 0; req_addr0 = 9'h020;
    wait_en(1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rd_en !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_hold: cycle %0d rd_en=%0b, required 1", i + 1, rd_en);
      end
    end
    @(posedge clk); #1;
    req0 = 0;
    n_checks++;
    if (rd_en !== 1'b0 || ack0 !== 1'b1 || err0 !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_abort: rd_en=%0b ack0=%0b err0=%0b, required 0 1 1", rd_en, ack0, err0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_done_at_timeout();
    bit ok;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h5A5A));
    req0 = 1; req_we0 = 0; req_addr0 = 9'h021;
    wait_en(1'b0, ok);
    drive_done(1'b0, 3, 1, 16'h5A5A, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    bit ok;
    nreset = 1'b0;
    req0 = 1; req1 = 1; req_we0 = 0; req_we1 = 0;
    req_addr0 = 9'h0A0; req_addr1 = 9'h1B0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'(i & 1), 1'b0, 16'h1000 + 16'(i)));
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_en(1'b0, ok);
      n_checks++;
      if (grant !== 1'(i & 1) || rd_addr !== ((i & 1) != 0 ? 9'h1B0 : 9'h0A0)) begin
        n_fail++;
        $display("FAIL rr_grant: transfer %0d grant=%0b rd_addr=%h, required grant=%0b", i, grant, rd_addr, 1'(i & 1));
      end
      drive_done(1'b0, 1, 1, 16'h1000 + 16'(i), i == 3);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_transfer();
    bit ok;
    req1 = 1; req_we1 = 0; req_addr1 = 9'h033;
    wait_en(1'b0, ok);
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (rd_en !== 1'b0 || busy !== 1'b0 || ack1 !== 1'b0 || grant !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rd_en=%0b busy=%0b ack1=%0b grant=%0b, required 0 0 0 0", rd_en, busy, ack1, grant);
    end
    req0 = 1; req_we0 = 0; req_addr0 = 9'h044;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h7777));
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    wait_en(1'b0, ok);
    n_checks++;
    if (grant !== 1'b0 || rd_addr !== 9'h044) begin
      n_fail++;
      $display("FAIL post_reset_tie: grant=%0b rd_addr=%h, required 0 044", grant, rd_addr);
    end
    drive_done(1'b0, 1, 1, 16'h7777, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      ack_monitor();
    join_none
    test_reset();
    test_single_read();
    test_single_write();
    test_timeout();
    test_done_at_timeout();
    test_round_robin();
    test_reset_mid_transfer();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_acks: %0d expected acks outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
